syscall_responder: RTL

- Services the `syscall` instruction when it retires in the WB stage of the 5-stage pipeline.
- Uses the `v0` and `a0` values that the pipeline forwards alongside the instruction.
- Supported services:
  - print: latch `a0` into a display register, then stall the pipeline for a fixed hold time.
  - halt: freeze the pipeline until the operator presses a resume button.
  - all other codes: retire with no effect.
- Drives the global `stall` into the PC and pipeline-buffer enables, and keeps a retired-syscall counter for debug.

---
 rtl/syscall_responder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/syscall_responder.sv
// Services a retired syscall at WB: print latches a0 and holds the pipeline for a fixed
// time, halt freezes it until a synchronised resume press, and other codes retire silently.
`timescale 1ns/1ps

module syscall_responder #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned CODE_PRINT  = 34,
  parameter int unsigned CODE_HALT   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [31:0]      v0,
  input  logic [31:0]      a0,
  input  logic             go,
  output logic             stall,
  output logic             halted,
  output logic [31:0]      disp_data,
  output logic             disp_valid,
  output logic [CNT_W-1:0] sys_cnt,
  output logic             err
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [31:0] PRINT_CODE = 32'(CODE_PRINT);
  localparam logic [31:0] HALT_CODE  = 32'(CODE_HALT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRINT = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [31:0]       disp_data_q, disp_data_d;
  logic              disp_valid_q, disp_valid_d;
  logic [CNT_W-1:0]  sys_cnt_q, sys_cnt_d;
  logic              err_q, err_d;
  logic              go_s1_q, go_s1_d;
  logic              go_s2_q, go_s2_d;
  logic              go_prev_q, go_prev_d;
  logic              go_rise;
  logic              is_print;
  logic              is_halt;

  // The resume button is asynchronous: two flops for metastability, a third for edge detect.
  always_comb begin
    go_s1_d   = go;
    go_s2_d   = go_s1_q;
    go_prev_d = go_s2_q;
  end

  assign go_rise  = go_s2_q & ~go_prev_q;
  assign is_print = (v0 == PRINT_CODE);
  assign is_halt  = (v0 == HALT_CODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_s1_q   <= 1'b0;
      go_s2_q   <= 1'b0;
      go_prev_q <= 1'b0;
    end else begin
      go_s1_q   <= go_s1_d;
      go_s2_q   <= go_s2_d;
      go_prev_q <= go_prev_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = 1'b0;
    sys_cnt_d    = sys_cnt_q;
    err_d        = err_q;

    // A request while busy means the pipeline ignored stall; drop it but remember.
    if (req && (state_q != ST_IDLE)) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          sys_cnt_d = sys_cnt_q + CNT_W'(1);
          if (is_print) begin
            disp_data_d  = a0;
            disp_valid_d = 1'b1;
            hold_cnt_d   = HOLD_INIT;
            state_d      = ST_PRINT;
          end else if (is_halt) begin
            state_d = ST_HALT;
          end
        end
      end
      ST_PRINT: begin
        if (hold_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      ST_HALT: begin
        if (go_rise) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      sys_cnt_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      sys_cnt_q    <= sys_cnt_d;
      err_q        <= err_d;
    end
  end

  // Stall in the accept cycle too, so the instruction behind the syscall never advances.
  assign stall = rst_n & ((state_q != ST_IDLE) | (req & (is_print | is_halt)));

  assign halted     = (state_q == ST_HALT);
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign sys_cnt    = sys_cnt_q;
  assign err        = err_q;

endmodule
